// File: rtl/call_return_ctrl_if.sv
// Decode/stack/fetch signal bundle for call_return_ctrl.
// slave is the controller side; master is the surrounding pipeline.
interface call_return_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 9
);
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] stk_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_out;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             busy;
  logic [CNT_W-1:0] depth;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  call, ret, target, pc_next, stk_out,
    output stk_data, stk_push, stk_pop, redirect, redirect_pc,
           busy, depth, overflow, underflow
  );

  modport master (
    output call, ret, target, pc_next, stk_out,
    input  stk_data, stk_push, stk_pop, redirect, redirect_pc,
           busy, depth, overflow, underflow
  );
endinterface

// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer in front of a flagless return-address stack.
// Tracks stack depth, refuses overflow/underflow, and issues fetch redirects.
module call_return_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  call_return_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] depth_reg, depth_next;
  logic [WIDTH-1:0] stk_data_reg, stk_data_next;
  logic             stk_push_reg, stk_push_next;
  logic             stk_pop_reg, stk_pop_next;
  logic             redirect_reg, redirect_next;
  logic [WIDTH-1:0] redirect_pc_reg, redirect_pc_next;
  logic             busy_reg, busy_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      depth_reg       <= '0;
      stk_data_reg    <= '0;
      stk_push_reg    <= 1'b0;
      stk_pop_reg     <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      busy_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      depth_reg       <= depth_next;
      stk_data_reg    <= stk_data_next;
      stk_push_reg    <= stk_push_next;
      stk_pop_reg     <= stk_pop_next;
      redirect_reg    <= redirect_next;
      redirect_pc_reg <= redirect_pc_next;
      busy_reg        <= busy_next;
      overflow_reg    <= overflow_next;
      underflow_reg   <= underflow_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    depth_next       = depth_reg;
    stk_data_next    = stk_data_reg;
    stk_push_next    = 1'b0;
    stk_pop_next     = 1'b0;
    redirect_next    = 1'b0;
    redirect_pc_next = redirect_pc_reg;
    busy_next        = busy_reg;
    overflow_next    = overflow_reg;
    underflow_next   = underflow_reg;

    unique case (state_reg)
      IDLE: begin
        // CALL has priority when decode illegally raises both.
        if (bus.call) begin
          if (depth_reg < CNT_W'(DEPTH)) begin
            stk_push_next    = 1'b1;
            stk_data_next    = bus.pc_next;
            redirect_next    = 1'b1;
            redirect_pc_next = bus.target;
            depth_next       = depth_reg + CNT_W'(1);
          end else begin
            overflow_next = 1'b1;
          end
        end else if (bus.ret) begin
          if (depth_reg != '0) begin
            stk_pop_next = 1'b1;
            busy_next    = 1'b1;
            depth_next   = depth_reg - CNT_W'(1);
            state_next   = POP;
          end else begin
            underflow_next = 1'b1;
          end
        end
      end
      // The stack presents the popped word at the edge leaving POP.
      POP: begin
        state_next = WAIT;
      end
      WAIT: begin
        redirect_next    = 1'b1;
        redirect_pc_next = bus.stk_out;
        busy_next        = 1'b0;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.stk_data    = stk_data_reg;
  assign bus.stk_push    = stk_push_reg;
  assign bus.stk_pop     = stk_pop_reg;
  assign bus.redirect    = redirect_reg;
  assign bus.redirect_pc = redirect_pc_reg;
  assign bus.busy        = busy_reg;
  assign bus.depth       = depth_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural 256-entry stack attached.
module tb_call_return_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  call_return_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  call_return_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: output register updates on the edge after stk_pop.
  logic [WIDTH-1:0] stk_mem [0:DEPTH-1];
  logic [CNT_W-1:0] sp;
  logic [WIDTH-1:0] stk_out_reg;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp          <= '0;
      stk_out_reg <= '0;
    end else if (bus.stk_push) begin
      stk_mem[sp[7:0]] <= bus.stk_data;
      sp               <= sp + 9'd1;
    end else if (bus.stk_pop) begin
      stk_out_reg <= stk_mem[8'(sp - 9'd1)];
      sp          <= sp - 9'd1;
    end
  end

  assign bus.stk_out = stk_out_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push and pop must never be asserted together.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.stk_push === 1'b1 && bus.stk_pop === 1'b1)
      check_eq("push_pop_excl", 32'd1, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [15:0] tgt, input logic [15:0] pcn, input int exp_depth);
    bus.call = 1'b1;
    bus.target = tgt;
    bus.pc_next = pcn;
    tick();
    bus.call = 1'b0;
    check_eq("call_push", 32'(bus.stk_push), 32'd1);
    check_eq("call_data", 32'(bus.stk_data), 32'(pcn));
    check_eq("call_redir", 32'(bus.redirect), 32'd1);
    check_eq("call_rpc", 32'(bus.redirect_pc), 32'(tgt));
    check_eq("call_depth", 32'(bus.depth), 32'(exp_depth));
    $display("call target=0x%04h pc_next=0x%04h depth=%0d", tgt, pcn, bus.depth);
  endtask

  task automatic do_ret(input logic [15:0] exp_pc, input int exp_depth);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check_eq("ret_pop", 32'(bus.stk_pop), 32'd1);
    check_eq("ret_busy0", 32'(bus.busy), 32'd1);
    check_eq("ret_depth", 32'(bus.depth), 32'(exp_depth));
    tick();
    check_eq("ret_pop_off", 32'(bus.stk_pop), 32'd0);
    check_eq("ret_busy1", 32'(bus.busy), 32'd1);
    check_eq("ret_noredir", 32'(bus.redirect), 32'd0);
    tick();
    check_eq("ret_redir", 32'(bus.redirect), 32'd1);
    check_eq("ret_rpc", 32'(bus.redirect_pc), 32'(exp_pc));
    check_eq("ret_busy2", 32'(bus.busy), 32'd0);
    $display("ret redirect_pc=0x%04h depth=%0d", bus.redirect_pc, bus.depth);
    tick();
    check_eq("ret_redir_off", 32'(bus.redirect), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_push"}, 32'(bus.stk_push), 32'd0);
    check_eq({tag, "_pop"}, 32'(bus.stk_pop), 32'd0);
    check_eq({tag, "_data"}, 32'(bus.stk_data), 32'd0);
    check_eq({tag, "_redir"}, 32'(bus.redirect), 32'd0);
    check_eq({tag, "_rpc"}, 32'(bus.redirect_pc), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_depth"}, 32'(bus.depth), 32'd0);
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check_eq({tag, "_udf"}, 32'(bus.underflow), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.call = 1'b0;
    bus.ret = 1'b0;
    bus.target = '0;
    bus.pc_next = '0;
    reset = 1'b0;
    #23;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single CALL then RET through the attached stack.
    do_call(16'h0040, 16'h0011, 1);
    tick();
    check_eq("call_push_off", 32'(bus.stk_push), 32'd0);
    check_eq("call_redir_off", 32'(bus.redirect), 32'd0);
    do_ret(16'h0011, 0);

    // Nested calls unwind in LIFO order.
    do_call(16'h1000, 16'h0101, 1);
    do_call(16'h2000, 16'h0202, 2);
    do_call(16'h3000, 16'h0303, 3);
    do_ret(16'h0303, 2);
    do_ret(16'h0202, 1);
    do_ret(16'h0101, 0);

    // Underflow: RET on an empty stack is refused.
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check_eq("udf_flag", 32'(bus.underflow), 32'd1);
    check_eq("udf_pop", 32'(bus.stk_pop), 32'd0);
    check_eq("udf_redir", 32'(bus.redirect), 32'd0);
    check_eq("udf_busy", 32'(bus.busy), 32'd0);
    check_eq("udf_depth", 32'(bus.depth), 32'd0);
    $display("ret at depth 0 underflow=%0d", bus.underflow);

    // Fill to capacity, then one more CALL must be refused.
    bus.call = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.pc_next = 16'(i);
      bus.target = 16'h8000 | 16'(i);
      tick();
    end
    bus.call = 1'b0;
    check_eq("fill_depth", 32'(bus.depth), 32'd256);
    check_eq("fill_ovf", 32'(bus.overflow), 32'd0);
    check_eq("fill_udf_sticky", 32'(bus.underflow), 32'd1);
    $display("filled stack depth=%0d", bus.depth);
    tick();
    bus.call = 1'b1;
    bus.pc_next = 16'hdead;
    bus.target = 16'hbeef;
    tick();
    bus.call = 1'b0;
    check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
    check_eq("ovf_push", 32'(bus.stk_push), 32'd0);
    check_eq("ovf_redir", 32'(bus.redirect), 32'd0);
    check_eq("ovf_depth", 32'(bus.depth), 32'd256);
    $display("call at full overflow=%0d depth=%0d", bus.overflow, bus.depth);

    // Sticky flags clear only through reset.
    tick();
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
    #2 reset = 1'b0;
    #2;
    check_all_zero("rst2");
    reset = 1'b1;
    tick();

    // Simultaneous call+ret: CALL wins.
    do_call(16'h0a00, 16'h0aa1, 1);
    do_call(16'h0b00, 16'h0bb2, 2);
    $display("NOTE illegal decode: call and ret asserted together at depth 2");
    bus.call = 1'b1;
    bus.ret = 1'b1;
    bus.target = 16'h0c00;
    bus.pc_next = 16'h0cc3;
    tick();
    bus.call = 1'b0;
    bus.ret = 1'b0;
    check_eq("both_push", 32'(bus.stk_push), 32'd1);
    check_eq("both_pop", 32'(bus.stk_pop), 32'd0);
    check_eq("both_depth", 32'(bus.depth), 32'd3);
    check_eq("both_rpc", 32'(bus.redirect_pc), 32'h0c00);
    check_eq("both_busy", 32'(bus.busy), 32'd0);
    tick();

    // CALL pulsed while busy is ignored.
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check_eq("busy_pop", 32'(bus.stk_pop), 32'd1);
    check_eq("busy_flag", 32'(bus.busy), 32'd1);
    bus.call = 1'b1;
    bus.target = 16'h0d00;
    bus.pc_next = 16'h0dd4;
    tick();
    bus.call = 1'b0;
    check_eq("busy_nopush", 32'(bus.stk_push), 32'd0);
    check_eq("busy_noredir", 32'(bus.redirect), 32'd0);
    check_eq("busy_depth", 32'(bus.depth), 32'd2);
    tick();
    check_eq("busy_ret_redir", 32'(bus.redirect), 32'd1);
    check_eq("busy_ret_rpc", 32'(bus.redirect_pc), 32'h0cc3);
    check_eq("busy_ret_depth", 32'(bus.depth), 32'd2);
    $display("ret during-busy call ignored redirect_pc=0x%04h depth=%0d", bus.redirect_pc, bus.depth);
    tick();
    check_eq("busy_after_push", 32'(bus.stk_push), 32'd0);

    // Asynchronous reset while in POP abandons the RET.
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check_eq("abort_pop", 32'(bus.stk_pop), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("abort");
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("abort_noredir", 32'(bus.redirect), 32'd0);
    end
    check_eq("abort_depth", 32'(bus.depth), 32'd0);
    check_eq("abort_busy_off", 32'(bus.busy), 32'd0);
    $display("reset in POP: redirect=%0d depth=%0d", bus.redirect, bus.depth);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
- Control stage directly upstream of the processor's 16-bit hardware return-address stack.
- Turns decoded CALL/RET requests into stack push/pop strobes and consumes the popped stack word.
- Issues a one-cycle PC redirect to fetch.
- The stack has no full/empty flags, so this block tracks depth and blocks overflow and underflow.

Parameters:
- WIDTH, 16, address/data width of stack entries and PCs.
- DEPTH, 256, stack capacity in entries; must match the attached stack.
- CNT_W, 9, width of the depth counter; must hold 0..DEPTH inclusive.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- call  input  1  decode requests CALL; sampled only in IDLE.
- ret  input  1  decode requests RET; sampled only in IDLE.
- target  input  WIDTH  CALL destination address, sampled with call.
- pc_next  input  WIDTH  return address (PC+1), sampled with call.
- stk_data  output  WIDTH  word to push to the stack.
- stk_push  output  1  push strobe to the stack, one cycle.
- stk_pop  output  1  pop strobe to the stack, one cycle.
- stk_out  input  WIDTH  popped word from the stack; valid from the edge after stk_pop.
- redirect  output  1  one-cycle PC redirect strobe to fetch.
- redirect_pc  output  WIDTH  new PC, valid while redirect=1.
- busy  output  1  high while a RET is in flight; decode must hold.
- depth  output  CNT_W  current number of stack entries.
- overflow  output  1  sticky: a CALL was refused because the stack was full.
- underflow  output  1  sticky: a RET was refused because the stack was empty.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, depth=0.
  - stk_data=0, stk_push=0, stk_pop=0.
  - redirect=0, redirect_pc=0.
  - busy=0, overflow=0, underflow=0.
  - Reset mid-RET abandons the RET; no redirect is issued.
  - The stack's pointer must be cleared by the same reset event at integration level.
- FSM states: IDLE, POP, WAIT.
- Strobes: stk_push, stk_pop and redirect default to 0 every cycle unless set below, so each is a one-cycle pulse.
- IDLE, call=1 at edge E0:
  - If depth<DEPTH: stk_push<=1, stk_data<=pc_next, redirect<=1, redirect_pc<=target, depth<=depth+1. Remain IDLE.
  - Result: the push and the redirect are both visible in the cycle after E0.
  - A new command is accepted at E0+1.
  - If depth==DEPTH: no push, no redirect, overflow<=1, depth unchanged.
- IDLE, ret=1 and call=0 at edge E0:
  - If depth>0: stk_pop<=1, busy<=1, depth<=depth-1, state<=POP.
  - If depth==0: no pop, no redirect, underflow<=1. Remain IDLE.
- POP, edge E1:
  - The stack updates its output at this edge.
  - stk_pop<=0, state<=WAIT.
- WAIT, edge E2:
  - redirect<=1, redirect_pc<=stk_out, busy<=0, state<=IDLE.
  - Result: redirect is visible in the cycle after E2, i.e. RET latency is 3 edges from acceptance.
- call/ret in POP or WAIT: ignored and not queued; decode must honour busy.
- call=1 and ret=1 together in IDLE: CALL wins, RET is dropped. This is illegal decode; the bench flags it.
- Never stk_push and stk_pop high in the same cycle.
- overflow/underflow are cleared only by reset.
- Depth arithmetic is unsigned CNT_W and never wraps; it is saturated by the refusal rules.

Test Plan:
1. Reset, then call=1, target=0x0040, pc_next=0x0011 -> next cycle: stk_push=1, stk_data=0x0011, redirect=1, redirect_pc=0x0040, depth=1.
2. After (1), with the stack attached, ret=1 -> stk_pop for 1 cycle, busy for 2 cycles, then redirect=1 with redirect_pc=0x0011, depth=0.
3. Calls with pc_next 0x0101, 0x0202, 0x0303, then three rets -> redirect_pc sequence 0x0303, 0x0202, 0x0101; depth 3→0.
4. ret at depth=0 -> underflow=1, no stk_pop, no redirect. Fill to DEPTH=256 with calls, then one more call -> overflow=1, no push, depth stays 256.
5. call=1 and ret=1 together at depth=2 -> CALL only, depth=3. Assert ret, then pulse call during busy -> the call is ignored.
6. Assert reset=0 asynchronously mid-clock in POP -> all outputs 0 immediately; no redirect after release; depth=0.
